// File: rtl/ft_tx_arbiter_if.sv
// ft_tx_arbiter_if: requester handshakes and FT600 TX FIFO write port
// shared by the two-channel TX arbiter.
//   slave  - arbiter side
//   master - requester / FIFO side
interface ft_tx_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_last;
    logic        req0_ready;

    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_last;
    logic        req1_ready;

    logic        tx_en;
    logic [15:0] tx_in;
    logic        tx_full;

    logic        busy;
    logic        grant;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output tx_en, tx_in,
        input  tx_full,
        output busy, grant
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  tx_en, tx_in,
        output tx_full,
        input  busy, grant
    );
endinterface

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: round-robin, packet-granular sharing of the FT600 245-mode
// TX FIFO write port between two 16-bit requesters. Each packet starts with
// a header {HDR_MAGIC, 7'b0, channel}; a packet is closed by a word with
// last=1 or forcibly after MAX_BURST payload words.
// Optional: define TX_TRAILER_EN to append a trailer {8'h5A, payload count}
// after every packet.
module ft_tx_arbiter #(
    parameter int unsigned MAX_BURST = 64,
    parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    ft_tx_arbiter_if.slave bus
);

`ifdef TX_TRAILER_EN
    typedef enum logic [1:0] {IDLE, HEADER, BURST, TRAILER} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, BURST} state_t;
`endif

    localparam logic [7:0] LAST_IDX = 8'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_q, rr_d;        // preferred channel for the next arbitration
    logic [7:0]  count_q, count_d;  // payload words of the current packet

    logic        g_valid;
    logic        g_last;
    logic [15:0] g_data;
    logic        xfer;
    logic        eop;

    // Select the granted requester and detect payload transfer / end of packet
    always_comb begin
        g_valid = grant_q ? bus.req1_valid : bus.req0_valid;
        g_last  = grant_q ? bus.req1_last  : bus.req0_last;
        g_data  = grant_q ? bus.req1_data  : bus.req0_data;
        xfer    = (state_q == BURST) && g_valid && !bus.tx_full;
        eop     = xfer && (g_last || (count_q == LAST_IDX));
    end

    // Next-state logic: arbitration, packet framing and burst counting
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_d = (rr_q ? bus.req1_valid : bus.req0_valid) ? rr_q : !rr_q;
                    count_d = '0;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (!bus.tx_full) state_d = BURST;
            end
            BURST: begin
                if (xfer) begin
                    count_d = count_q + 8'd1;
                    if (eop) begin
                        rr_d = !grant_q;
`ifdef TX_TRAILER_EN
                        state_d = TRAILER;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef TX_TRAILER_EN
            TRAILER: begin
                if (!bus.tx_full) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM and arbitration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

    // FIFO write port and requester readies, qualified combinationally with tx_full
    always_comb begin
        bus.tx_en      = 1'b0;
        bus.tx_in      = '0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state_q)
            HEADER: begin
                bus.tx_en = !bus.tx_full;
                bus.tx_in = {HDR_MAGIC, 7'b0, grant_q};
            end
            BURST: begin
                bus.tx_en      = g_valid && !bus.tx_full;
                bus.tx_in      = g_data;
                bus.req0_ready = !grant_q && !bus.tx_full;
                bus.req1_ready = grant_q && !bus.tx_full;
            end
`ifdef TX_TRAILER_EN
            TRAILER: begin
                bus.tx_en = !bus.tx_full;
                bus.tx_in = {8'h5A, count_q};
            end
`endif
            default: ;
        endcase
    end

    // Status outputs come straight from registered state
    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.grant = grant_q;
    end

endmodule
